mpu_event_bridge: RTL

FPGA-side endpoint of the HPS MPU event interface (h2f_mpu_events) in the image-filter system. It turns HPS `SEV` pulses (evento) into single-cycle filter start strobes. It queues filter-done completions and signals each one back to the ARM cores as a timed eventi pulse, gated on core WFE standby status with a timeout fallback. It also reports overrun and overflow conditions as sticky flags.

---
 rtl/mpu_event_bridge.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mpu_event_bridge.sv
// FPGA endpoint of the HPS MPU event interface: SEV -> filter start strobe,
// filter completions -> WFE-gated eventi pulses, plus sticky overrun/overflow flags.
module mpu_event_bridge #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int CNT_W        = 4,
  parameter int WAKE_TIMEOUT = 1024
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             hps_evento,
  input  logic [1:0]       hps_standbywfe,
  input  logic [1:0]       hps_standbywfi,
  output logic             hps_eventi,
  input  logic             filter_busy,
  input  logic             filter_done,
  output logic             start_pulse,
  output logic [CNT_W-1:0] pending,
  output logic [1:0]       cores_wfi,
  output logic             start_dropped,
  output logic             done_overflow,
  input  logic             clear_flags
);

  localparam int MAX_A = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_C = (MAX_A > WAKE_TIMEOUT) ? MAX_A : WAKE_TIMEOUT;
  localparam int PW    = $clog2(MAX_C) + 1;

  localparam logic [PW-1:0]    PULSE_LAST   = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0]    GAP_LAST     = PW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0]    TIMEOUT_LAST = PW'(WAKE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    phase_reg, phase_next;
  logic             eventi_next;
  logic             take;
  logic [CNT_W-1:0] pending_next;
  logic             overflow_set;

  logic       evt_meta, evt_s, evt_prev;
  logic [1:0] wfe_meta, wfe_s;
  logic [1:0] wfi_meta;
  logic       start_edge;

  assign start_edge = evt_s & ~evt_prev;

  // Two-flop synchronizers, start edge detect, pending counter and sticky flags.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      evt_meta      <= 1'b0;
      evt_s         <= 1'b0;
      evt_prev      <= 1'b0;
      wfe_meta      <= 2'b00;
      wfe_s         <= 2'b00;
      wfi_meta      <= 2'b00;
      cores_wfi     <= 2'b00;
      start_pulse   <= 1'b0;
      start_dropped <= 1'b0;
      done_overflow <= 1'b0;
      pending       <= '0;
    end else begin
      evt_meta      <= hps_evento;
      evt_s         <= evt_meta;
      evt_prev      <= evt_s;
      wfe_meta      <= hps_standbywfe;
      wfe_s         <= wfe_meta;
      wfi_meta      <= hps_standbywfi;
      cores_wfi     <= wfi_meta;
      start_pulse   <= start_edge;
      start_dropped <= (start_edge & filter_busy) | (start_dropped & ~clear_flags);
      done_overflow <= overflow_set | (done_overflow & ~clear_flags);
      pending       <= pending_next;
    end
  end

  always_comb begin
    pending_next = pending;
    overflow_set = 1'b0;
    if (filter_done && !take) begin
      if (pending == CNT_MAX) overflow_set = 1'b1;
      else                    pending_next = pending + 1'b1;
    end else if (!filter_done && take) begin
      pending_next = pending - 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg  <= IDLE;
      phase_reg  <= '0;
      hps_eventi <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      hps_eventi <= eventi_next;
    end
  end

  // phase_reg doubles as the WFE wait counter in IDLE and the pulse/gap timer elsewhere.
  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    eventi_next = 1'b0;
    take        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending != '0 && (|wfe_s || phase_reg == TIMEOUT_LAST)) begin
          state_next  = PULSE;
          phase_next  = '0;
          eventi_next = 1'b1;
          take        = 1'b1;
        end else if (pending != '0) begin
          phase_next = phase_reg + 1'b1;
        end else begin
          phase_next = '0;
        end
      end
      PULSE: begin
        if (phase_reg == PULSE_LAST) begin
          state_next = GAP;
          phase_next = '0;
        end else begin
          phase_next  = phase_reg + 1'b1;
          eventi_next = 1'b1;
        end
      end
      GAP: begin
        if (phase_reg == GAP_LAST) begin
          state_next = IDLE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

endmodule
